// File: rtl/popcnt_rr_arbiter.sv
// popcnt_rr_arbiter
//   Shares one combinational popcount datapath between NUM_REQ requesters.
//   A round-robin arbiter picks one valid request per cycle; the popcount and
//   requester index are captured in a single output register and returned over
//   a valid/ready channel, sustaining one result per cycle.
//   Optional macro POPCNT_ARB_STATS_EN adds a saturating 32-bit running total
//   of counted bits on o_stat_total; without it o_stat_total is constant zero.
module popcnt_rr_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NUM_REQ = 4,
    localparam int CNT_W  = $clog2(WIDTH + 1),
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [CNT_W-1:0]         o_rsp_count,
    output logic [ID_W-1:0]          o_rsp_id,
    output logic [31:0]              o_stat_total
);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] rsp_count_q, rsp_count_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic             accept_en;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [WIDTH-1:0] sel_word;
    logic [CNT_W-1:0] sel_count;
    logic             req_hs;
    logic             rsp_hs;

    assign accept_en = !rsp_valid_q || i_rsp_ready;
    assign rsp_hs    = rsp_valid_q && i_rsp_ready;

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        int unsigned cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && i_req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Ready is one-hot on the granted requester, only when the output can take it.
    always_comb begin
        o_req_ready = '0;
        if (grant_found && accept_en) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    assign req_hs = grant_found && accept_en;

    // Shared popcount datapath on the granted word.
    always_comb begin
        sel_word  = i_req_data[grant_idx*WIDTH +: WIDTH];
        sel_count = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            sel_count = sel_count + CNT_W'(sel_word[b]);
        end
    end

    // Next-state for the response register and the round-robin pointer.
    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_count_d = rsp_count_q;
        rsp_id_d    = rsp_id_q;
        if (req_hs) begin
            rsp_valid_d = 1'b1;
            rsp_count_d = sel_count;
            rsp_id_d    = grant_idx;
            ptr_d       = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
        end else if (rsp_hs) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register and pointer state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_count_q <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_count_q <= rsp_count_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_count = rsp_count_q;
    assign o_rsp_id    = rsp_id_q;

`ifdef POPCNT_ARB_STATS_EN
    logic [31:0] stat_total_q, stat_total_d;

    // Saturating accumulation of delivered counts.
    always_comb begin
        logic [32:0] sum;
        sum          = {1'b0, stat_total_q} + 33'(rsp_count_q);
        stat_total_d = stat_total_q;
        if (rsp_hs) begin
            stat_total_d = sum[32] ? '1 : sum[31:0];
        end
    end

    // Statistics register, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_total_q <= '0;
        end else begin
            stat_total_q <= stat_total_d;
        end
    end

    assign o_stat_total = stat_total_q;
`else
    assign o_stat_total = '0;
`endif

endmodule

// File: tb/tb_popcnt_rr_arbiter.sv
// Self-checking bench for popcnt_rr_arbiter (WIDTH=64, NUM_REQ=4).
module tb_popcnt_rr_arbiter;

    localparam int WIDTH   = 64;
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 7;
    localparam int ID_W    = 2;
`ifdef POPCNT_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic                     i_clk = 1'b0;
    logic                     i_rst_n = 1'b0;
    logic [NUM_REQ-1:0]       i_req_valid = '0;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic [NUM_REQ*WIDTH-1:0] i_req_data;
    logic                     o_rsp_valid;
    logic                     i_rsp_ready = 1'b0;
    logic [CNT_W-1:0]         o_rsp_count;
    logic [ID_W-1:0]          o_rsp_id;
    logic [31:0]              o_stat_total;

    logic [WIDTH-1:0] req_data [NUM_REQ];

    int n_pass = 0;
    int n_total = 0;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            i_req_data[k*WIDTH +: WIDTH] = req_data[k];
        end
    end

    always #5 i_clk = ~i_clk;

    popcnt_rr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_data  (i_req_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_count (o_rsp_count),
        .o_rsp_id    (o_rsp_id),
        .o_stat_total(o_stat_total)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_req_valid = '0;
        i_rsp_ready = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) req_data[k] = '0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        i_req_valid = 4'b0010;
        req_data[1] = 64'h0000_0000_0000_00FF;
        i_rsp_ready = 1'b0;
        tick();
        n_total++;
        if (o_rsp_valid !== 1'b1 || o_rsp_count !== 7'd8)
            $display("FAIL reset_pre valid=%b count=%0d required valid=1 count=8", o_rsp_valid, o_rsp_count);
        else n_pass++;
        #2;
        i_rst_n = 1'b0;
        i_req_valid = '0;
        #1;
        n_total++;
        if (o_rsp_valid !== 1'b0 || o_rsp_count !== '0 || o_rsp_id !== '0 || o_req_ready !== '0 || o_stat_total !== '0)
            $display("FAIL reset_async valid=%b count=%0d id=%0d ready=%b total=%0d required all 0",
                     o_rsp_valid, o_rsp_count, o_rsp_id, o_req_ready, o_stat_total);
        else n_pass++;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        n_total++;
        if (o_rsp_valid !== 1'b0)
            $display("FAIL reset_after valid=%b required 0", o_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        req_data[1] = 64'hF0F0_0000_0000_000F;
        i_req_valid = 4'b0010;
        i_rsp_ready = 1'b1;
        #1;
        n_total++;
        if (o_req_ready !== 4'b0010)
            $display("FAIL single_ready ready=%b required 0010", o_req_ready);
        else n_pass++;
        tick();
        i_req_valid = '0;
        n_total++;
        if (o_rsp_valid !== 1'b1 || o_rsp_count !== 7'd12 || o_rsp_id !== 2'd1)
            $display("FAIL single_rsp valid=%b count=%0d id=%0d required 1/12/1", o_rsp_valid, o_rsp_count, o_rsp_id);
        else n_pass++;
        tick();
        n_total++;
        if (o_rsp_valid !== 1'b0)
            $display("FAIL single_drain valid=%b required 0", o_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < NUM_REQ; k++) req_data[k] = {$urandom(), $urandom()};
        i_req_valid = 4'hF;
        i_rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if (o_rsp_valid !== 1'b1 || o_rsp_id !== ID_W'(i % NUM_REQ)
                || o_rsp_count !== CNT_W'($countones(req_data[i % NUM_REQ])))
                $display("FAIL rr_%0d valid=%b id=%0d count=%0d required 1/%0d/%0d", i, o_rsp_valid,
                         o_rsp_id, o_rsp_count, i % NUM_REQ, $countones(req_data[i % NUM_REQ]));
            else n_pass++;
        end
        i_req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [CNT_W-1:0] held;
        apply_reset();
        req_data[0] = 64'h0000_0000_0000_0007;
        req_data[2] = 64'h8000_0000_0000_0001;
        held = 7'd3;
        i_req_valid = 4'b0101;
        i_rsp_ready = 1'b0;
        tick();
        i_req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (o_req_ready !== '0 || o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd0 || o_rsp_count !== held)
                $display("FAIL bp_hold_%0d ready=%b valid=%b id=%0d count=%0d required 0000/1/0/3",
                         i, o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_count);
            else n_pass++;
            tick();
        end
        i_rsp_ready = 1'b1;
        #1;
        n_total++;
        if (o_req_ready !== 4'b0100)
            $display("FAIL bp_release_ready ready=%b required 0100", o_req_ready);
        else n_pass++;
        tick();
        i_req_valid = '0;
        n_total++;
        if (o_rsp_valid !== 1'b1 || o_rsp_id !== 2'd2 || o_rsp_count !== 7'd2)
            $display("FAIL bp_second valid=%b id=%0d count=%0d required 1/2/2", o_rsp_valid, o_rsp_id, o_rsp_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_extremes();
        apply_reset();
        req_data[3] = '0;
        i_req_valid = 4'b1000;
        i_rsp_ready = 1'b1;
        tick();
        n_total++;
        if (o_rsp_valid !== 1'b1 || o_rsp_count !== 7'd0 || o_rsp_id !== 2'd3)
            $display("FAIL ext_zero valid=%b count=%0d id=%0d required 1/0/3", o_rsp_valid, o_rsp_count, o_rsp_id);
        else n_pass++;
        req_data[3] = '1;
        tick();
        i_req_valid = '0;
        n_total++;
        if (o_rsp_valid !== 1'b1 || o_rsp_count !== 7'd64 || o_rsp_id !== 2'd3)
            $display("FAIL ext_ones valid=%b count=%0d id=%0d required 1/64/3", o_rsp_valid, o_rsp_count, o_rsp_id);
        else n_pass++;
        tick();
    endtask

    task automatic test_stats();
        apply_reset();
        req_data[0] = '1;
        i_req_valid = 4'b0001;
        i_rsp_ready = 1'b1;
        repeat (3) tick();
        i_req_valid = '0;
        tick();
        n_total++;
        if (o_stat_total !== (STATS_EN ? 32'd192 : 32'd0))
            $display("FAIL stats_sum total=%0d required %0d", o_stat_total, STATS_EN ? 192 : 0);
        else n_pass++;
`ifdef POPCNT_ARB_STATS_EN
        force dut.stat_total_q = 32'hFFFF_FFF0;
        #1;
        release dut.stat_total_q;
        i_req_valid = 4'b0001;
        tick();
        i_req_valid = '0;
        tick();
        n_total++;
        if (o_stat_total !== 32'hFFFF_FFFF)
            $display("FAIL stats_sat total=%h required ffffffff", o_stat_total);
        else n_pass++;
`endif
    endtask

    // Randomized traffic against a transaction-level model of the arbiter.
    task automatic test_random();
        int          m_ptr = 0;
        bit          m_valid = 0;
        int          m_count = 0;
        int          m_id = 0;
        longint      m_total = 0;
        bit          accept;
        int          gk;
        logic [3:0]  exp_ready;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!i_req_valid[k] && ($urandom_range(0, 1) == 1)) begin
                    case ($urandom_range(0, 3))
                        0:       req_data[k] = '0;
                        1:       req_data[k] = '1;
                        default: req_data[k] = {$urandom(), $urandom()};
                    endcase
                    i_req_valid[k] = 1'b1;
                end
            end
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            #3;
            accept = !m_valid || i_rsp_ready;
            gk = -1;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (gk < 0 && i_req_valid[(m_ptr + j) % NUM_REQ]) gk = (m_ptr + j) % NUM_REQ;
            end
            exp_ready = (accept && gk >= 0) ? 4'(1 << gk) : 4'b0000;
            n_total++;
            if (o_req_ready !== exp_ready || o_rsp_valid !== m_valid
                || (m_valid && (o_rsp_count !== CNT_W'(m_count) || o_rsp_id !== ID_W'(m_id)))
                || o_stat_total !== (STATS_EN ? 32'(m_total) : 32'd0))
                $display("FAIL rand_%0d ready=%b valid=%b count=%0d id=%0d total=%0d required %b/%b/%0d/%0d/%0d",
                         cyc, o_req_ready, o_rsp_valid, o_rsp_count, o_rsp_id, o_stat_total,
                         exp_ready, m_valid, m_count, m_id, STATS_EN ? m_total : 0);
            else n_pass++;
            if (m_valid && i_rsp_ready) begin
                m_total = m_total + m_count;
                if (m_total > 64'hFFFF_FFFF) m_total = 64'hFFFF_FFFF;
            end
            if (exp_ready != 0) begin
                m_count = $countones(req_data[gk]);
                m_id    = gk;
                m_valid = 1'b1;
                m_ptr   = (gk + 1) % NUM_REQ;
            end else if (i_rsp_ready) begin
                m_valid = 1'b0;
            end
            tick();
            i_req_valid = i_req_valid & ~exp_ready;
        end
        i_req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
